udp_tx_packer: RTL

//  Upstream feeder for the UDP transmit path. Accepts an application byte stream with frame

---
 rtl/udp_tx_pkg.sv | 11 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/udp_tx_packer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP transmit packer: TX FSM states and word geometry.
package udp_tx_pkg;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        GAP
    } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; writes when full and reads when empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] rd_q;
    logic             do_wr, do_rd;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = rd_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            rd_q   <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) begin
                rptr_q <= rptr_q + 1'b1;
                rd_q   <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/udp_tx_packer.sv
// Packs an application byte stream into big-endian words plus per-frame lengths and
// hands frames one at a time to the UDP sender with an inter-frame gap.
module udp_tx_packer
    import udp_tx_pkg::*;
#(
    parameter int WORD_DEPTH = 512,
    parameter int LEN_DEPTH  = 8,
    parameter int MAX_BYTES  = 1472,
    parameter int IFG_CYCLES = 12
) (
    input  logic                         eth_txc,
    input  logic                         rst,
    input  logic [7:0]                   s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic                         tx_start_en,
    output logic [15:0]                  tx_byte_num,
    input  logic                         tx_req,
    output logic [31:0]                  tx_data,
    input  logic                         tx_pkg_done,
    output logic [$clog2(LEN_DEPTH):0]   frames_pend,
    output logic                         err_underrun
);
    localparam int LW = $clog2(BYTES_PER_WORD);
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam int FW = $clog2(LEN_DEPTH) + 1;

    if (MAX_BYTES % BYTES_PER_WORD != 0) begin : g_max_bytes_chk
        $error("MAX_BYTES must be a multiple of BYTES_PER_WORD");
    end

    logic        wf_wr, wf_rd, wf_full, wf_empty;
    logic [31:0] wf_wdata, wf_rdata;
    logic        lf_wr, lf_rd, lf_full, lf_empty;
    logic [15:0] lf_wdata, lf_rdata;

    sync_fifo #(.WIDTH(32), .DEPTH(WORD_DEPTH)) u_word_fifo (
        .clk_i(eth_txc), .rst_i(rst),
        .wr_en_i(wf_wr), .wr_data_i(wf_wdata),
        .rd_en_i(wf_rd), .rd_data_o(wf_rdata),
        .full_o(wf_full), .empty_o(wf_empty)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk_i(eth_txc), .rst_i(rst),
        .wr_en_i(lf_wr), .wr_data_i(lf_wdata),
        .rd_en_i(lf_rd), .rd_data_o(lf_rdata),
        .full_o(lf_full), .empty_o(lf_empty)
    );

    // ---------------- packer ----------------
    logic [31:0]   word_q, word_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          accept, is_last;

    assign s_ready = !rst && !wf_full && !lf_full;
    assign accept  = s_valid && s_ready;
    assign is_last = s_last || (fcnt_q == 16'(MAX_BYTES - 1));

    always_comb begin
        wf_wdata = word_q | ({s_data, 24'h0} >> {lane_q, 3'b000});
        wf_wr    = accept && ((lane_q == LW'(BYTES_PER_WORD - 1)) || is_last);
        lf_wr    = accept && is_last;
        lf_wdata = fcnt_q + 16'd1;
        word_d   = word_q;
        lane_d   = lane_q;
        fcnt_d   = fcnt_q;
        if (accept) begin
            word_d = wf_wr ? '0 : wf_wdata;
            lane_d = wf_wr ? '0 : lane_q + 1'b1;
            fcnt_d = is_last ? '0 : fcnt_q + 16'd1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_e      state_q, state_d;
    logic [15:0]    words_left_q, words_left_d;
    logic [15:0]    byte_num_q, byte_num_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           start_q, start_d;
    logic           uflow_q, uflow_d;
    logic           err_q, err_d;
    logic [FW-1:0]  frames_q, frames_d;

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        byte_num_d   = byte_num_q;
        gap_d        = gap_q;
        start_d      = 1'b0;
        uflow_d      = uflow_q;
        err_d        = err_q;
        wf_rd        = 1'b0;
        lf_rd        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!lf_empty) begin
                    lf_rd   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                byte_num_d   = lf_rdata;
                words_left_d = 16'((17'(lf_rdata) + 17'd3) >> 2);
                start_d      = 1'b1;
                state_d      = SEND;
            end
            SEND: begin
                if (tx_req) begin
                    if (words_left_q != '0) begin
                        wf_rd        = 1'b1;
                        words_left_d = words_left_q - 16'd1;
                        uflow_d      = 1'b0;
                    end else begin
                        uflow_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
                if (tx_pkg_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // Drain words the sender never asked for so the next frame starts aligned.
                if (words_left_q != '0) begin
                    wf_rd        = 1'b1;
                    words_left_d = words_left_q - 16'd1;
                end
                if (gap_q != GW'(IFG_CYCLES - 1)) begin
                    gap_d = gap_q + 1'b1;
                end else if (words_left_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        frames_d = frames_q;
        case ({lf_wr, lf_rd})
            2'b10:   frames_d = frames_q + 1'b1;
            2'b01:   frames_d = frames_q - 1'b1;
            default: frames_d = frames_q;
        endcase
    end

    always_ff @(posedge eth_txc) begin
        if (rst) begin
            word_q       <= '0;
            lane_q       <= '0;
            fcnt_q       <= '0;
            state_q      <= IDLE;
            words_left_q <= '0;
            byte_num_q   <= '0;
            gap_q        <= '0;
            start_q      <= 1'b0;
            uflow_q      <= 1'b0;
            err_q        <= 1'b0;
            frames_q     <= '0;
        end else begin
            word_q       <= word_d;
            lane_q       <= lane_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            words_left_q <= words_left_d;
            byte_num_q   <= byte_num_d;
            gap_q        <= gap_d;
            start_q      <= start_d;
            uflow_q      <= uflow_d;
            err_q        <= err_d;
            frames_q     <= frames_d;
        end
    end

    assign tx_start_en  = start_q;
    assign tx_byte_num  = byte_num_q;
    assign tx_data      = uflow_q ? '0 : wf_rdata;
    assign frames_pend  = frames_q;
    assign err_underrun = err_q;
endmodule
